// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP with per-state strobes.
// Optional memory-wait watchdog enabled by defining CU_TIMEOUT_EN.
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic             imm,
  output logic [1:0]       alu_op,
  output logic [7:0]       ctrl_word,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_R       = 3'd1,
    CL_IALU    = 3'd2,
    CL_LOAD    = 3'd3,
    CL_STORE   = 3'd4,
    CL_BRANCH  = 3'd5,
    CL_JAL     = 3'd6
  } class_t;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = CL_R;
      7'b0010011: decode_class = CL_IALU;
      7'b0000011: decode_class = CL_LOAD;
      7'b0100011: decode_class = CL_STORE;
      7'b1100011: decode_class = CL_BRANCH;
      7'b1101111: decode_class = CL_JAL;
      default:    decode_class = CL_ILLEGAL;
    endcase
  endfunction

  // Watchdog limit must fit its counter and be at least one cycle.
  if (TIMEOUT_MAX < 1 || TIMEOUT_MAX >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
    $error("multicycle_control_unit: TIMEOUT_MAX out of range for TIMEOUT_W");
  end

  state_t             state_q, state_d;
  class_t             class_q, class_d;
  class_t             cls_dec;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               trap_q, trap_d;
  logic               trap_ill_q, trap_ill_d;
  logic               trap_to;
  logic               retire;
  logic               ir_write_c;

`ifdef CU_TIMEOUT_EN
  localparam logic [TIMEOUT_W:0] WD_LIMIT = (TIMEOUT_W+1)'(TIMEOUT_MAX);
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 trap_to_q, trap_to_d;
  logic [TIMEOUT_W:0]   wd_next;
  assign wd_next = {1'b0, wd_q} + (TIMEOUT_W+1)'(1);
  assign trap_to = trap_to_q;
`else
  assign trap_to = 1'b0;
`endif

  assign cls_dec = decode_class(opcode);

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    trap_d     = trap_q;
    trap_ill_d = trap_ill_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write_c = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    imm        = 1'b0;
    alu_op     = 2'b00;
`ifdef CU_TIMEOUT_EN
    wd_d       = wd_q;
    trap_to_d  = trap_to_q;
`endif
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (instr_valid) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        class_d = cls_dec;
        if (cls_dec == CL_ILLEGAL) begin
          state_d    = S_TRAP;
          trap_d     = 1'b1;
          trap_ill_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          CL_IALU: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            imm     = 1'b1;
            state_d = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src = 1'b1;
            imm     = 1'b1;
            state_d = S_MEM;
`ifdef CU_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
          CL_BRANCH: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          CL_JAL:  state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_read  = (class_q == CL_LOAD);
        dmem_write = (class_q == CL_STORE);
        if (class_q != CL_LOAD && class_q != CL_STORE) begin
          state_d = S_FETCH;
        end else if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
`ifdef CU_TIMEOUT_EN
        end else if (wd_next == WD_LIMIT) begin
          // mem_ready took priority above, so reaching the limit here is a real stall.
          state_d   = S_TRAP;
          trap_d    = 1'b1;
          trap_to_d = 1'b1;
        end else begin
          wd_d = wd_next[TIMEOUT_W-1:0];
`endif
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = (class_q == CL_JAL) ? 2'b10 : 2'b00;
        mem_to_reg = (class_q == CL_LOAD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      class_q    <= CL_ILLEGAL;
      instret_q  <= '0;
      trap_q     <= 1'b0;
      trap_ill_q <= 1'b0;
`ifdef CU_TIMEOUT_EN
      wd_q       <= '0;
      trap_to_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      instret_q  <= instret_d;
      trap_q     <= trap_d;
      trap_ill_q <= trap_ill_d;
`ifdef CU_TIMEOUT_EN
      wd_q       <= wd_d;
      trap_to_q  <= trap_to_d;
`endif
    end
  end

  // Gate the fetch handshake so a valid word seen while in reset never loads the IR.
  assign ir_write   = ir_write_c & rst_n;
  assign ctrl_word  = {dmem_read, mem_to_reg, alu_op, dmem_write, alu_src, reg_write, imm};
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = {trap_to, trap_ill_q};
  assign instret    = instret_q;

endmodule
